// File: rtl/stop_watch_lap.sv
// N-digit BCD stopwatch with prescaler, start/stop toggle, clear, lap/split
// capture with frozen display, and selectable wrap or saturate at full scale.
module stop_watch_lap #(
   parameter int TICK_DIV = 5_000_000,
   parameter int N_DIG    = 4,
   parameter int SEXA     = 1,
   parameter int WRAP     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 clr,
   input  logic                 lap,
   output logic [4*N_DIG-1:0]   disp_bcd,
   output logic                 running,
   output logic                 split,
   output logic                 ovf,
   output logic                 tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = 4 * N_DIG;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_SPLIT
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   lap_q, lap_d;
   logic            ovf_q, ovf_d;
   logic            tick_q, tick_d;

   logic [CW-1:0]   cnt_inc;
   logic [N_DIG:0]  carry;
   logic            full;
   logic            sat;
   logic            adv;

   // Ripple carry across the digits; carry out of the top digit means every
   // digit sits at its maximum, i.e. the count is at full scale.
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIG; gi++) begin : g_digit
         localparam logic [3:0] DMAX = (SEXA != 0 && gi == 2) ? 4'd5 : 4'd9;
         logic at_max;
         assign at_max                = (cnt_q[4*gi +: 4] == DMAX);
         assign carry[gi+1]           = carry[gi] & at_max;
         assign cnt_inc[4*gi +: 4]    = !carry[gi] ? cnt_q[4*gi +: 4] :
                                        at_max     ? 4'd0 : cnt_q[4*gi +: 4] + 4'd1;
      end
   endgenerate

   assign full = carry[N_DIG];
   // In saturate mode ovf can only be set by hitting full scale, so it doubles
   // as the "stuck at full scale" flag until the next clear.
   assign sat  = (WRAP == 0) && ovf_q;

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      lap_d   = lap_q;
      ovf_d   = ovf_q;
      tick_d  = 1'b0;
      adv     = 1'b0;

      if (clr) begin
         state_d = ST_IDLE;
         pre_d   = '0;
         cnt_d   = '0;
         lap_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RUN;
                  pre_d   = '0;
               end
            end
            ST_RUN: begin
               if (start) begin
                  state_d = ST_PAUSE;
               end else begin
                  adv = 1'b1;
                  if (lap) begin
                     state_d = ST_SPLIT;
                     lap_d   = cnt_q;
                  end
               end
            end
            ST_PAUSE: begin
               if (start) state_d = ST_RUN;
            end
            ST_SPLIT: begin
               if (start) begin
                  state_d = ST_PAUSE;
               end else begin
                  adv = 1'b1;
                  if (lap) state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // The stop edge itself does not advance the prescaler, so a resume
         // continues exactly where the pause left off.
         if (adv) begin
            if (pre_q == PRE_MAX) begin
               pre_d = '0;
               if (!sat) begin
                  if (full) begin
                     ovf_d = 1'b1;
                     if (WRAP != 0) begin
                        cnt_d  = cnt_inc;
                        tick_d = 1'b1;
                     end else begin
                        state_d = ST_PAUSE;
                     end
                  end else begin
                     cnt_d  = cnt_inc;
                     tick_d = 1'b1;
                  end
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         lap_q   <= '0;
         ovf_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         lap_q   <= lap_d;
         ovf_q   <= ovf_d;
         tick_q  <= tick_d;
      end
   end

   assign disp_bcd = (state_q == ST_SPLIT) ? lap_q : cnt_q;
   assign running  = (state_q == ST_RUN) || (state_q == ST_SPLIT);
   assign split    = (state_q == ST_SPLIT);
   assign ovf      = ovf_q;
   assign tick     = tick_q;

endmodule
